// File: rtl/miss_trace_player.sv
// Cache-miss trace replay source: a write-loaded trace RAM replayed one address
// per transfer on a valid/ready stream, with holes, loop mode, abort and status.
module miss_trace_player #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 256,
  parameter int PTR_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_idx,
  input  logic [ADDR_W-1:0] wr_data,
  input  logic              wr_skip,
  input  logic [PTR_W:0]    cfg_len,
  input  logic              loop_en,
  input  logic              start,
  input  logic              stop,
  output logic              miss_valid,
  input  logic              miss_ready,
  output logic [ADDR_W-1:0] miss_addr,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  miss_count
);

  typedef enum logic [0:0] {IDLE = 1'b0, PLAY = 1'b1} state_t;

  localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   LEN_ONE = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t              state_r, state_s;
  logic [ADDR_W:0]     mem_r [DEPTH];
  logic [PTR_W-1:0]    rd_ptr_r, rd_ptr_s, idx_s;
  logic [PTR_W:0]      len_r, len_s, fetch_cnt_r, fetch_cnt_s;
  logic                valid_r, valid_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic                done_r, done_s;
  logic [CNT_W-1:0]    count_r, count_s;
  logic                xfer_s, wrap_s;
  logic [ADDR_W:0]     entry_s;

  // Trace RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_idx] <= {wr_skip, wr_data};
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_s     = state_r;
    rd_ptr_s    = rd_ptr_r;
    len_s       = len_r;
    fetch_cnt_s = fetch_cnt_r;
    valid_s     = valid_r;
    addr_s      = addr_r;
    done_s      = 1'b0;
    count_s     = count_r;

    xfer_s  = valid_r & miss_ready;
    // fetch_cnt == len means every entry has been fetched: finish or wrap
    wrap_s  = (fetch_cnt_r == len_r);
    idx_s   = wrap_s ? {PTR_W{1'b0}} : rd_ptr_r;
    entry_s = mem_r[idx_s];

    if (xfer_s && (count_r != {CNT_W{1'b1}})) begin
      count_s = count_r + CNT_ONE;
    end else begin
      count_s = count_r;
    end

    case (state_r)
      IDLE: begin
        if (start && !stop) begin
          count_s = {CNT_W{1'b0}};
          if (cfg_len != {(PTR_W+1){1'b0}}) begin
            state_s     = PLAY;
            len_s       = cfg_len;
            rd_ptr_s    = {PTR_W{1'b0}};
            fetch_cnt_s = {(PTR_W+1){1'b0}};
          end else begin
            done_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      PLAY: begin
        if (stop) begin
          state_s = IDLE;
          valid_s = 1'b0;
        end else if (!valid_r || miss_ready) begin
          if (wrap_s && !loop_en) begin
            state_s = IDLE;
            valid_s = 1'b0;
            done_s  = 1'b1;
          end else begin
            // A hole drops valid for this single fetch slot and keeps the old address
            valid_s     = ~entry_s[ADDR_W];
            addr_s      = entry_s[ADDR_W] ? addr_r : entry_s[ADDR_W-1:0];
            rd_ptr_s    = idx_s + PTR_ONE;
            fetch_cnt_s = (wrap_s ? {(PTR_W+1){1'b0}} : fetch_cnt_r) + LEN_ONE;
          end
        end else begin
          state_s = PLAY;
        end
      end
      default: begin
        state_s = IDLE;
        valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      rd_ptr_r    <= {PTR_W{1'b0}};
      len_r       <= {(PTR_W+1){1'b0}};
      fetch_cnt_r <= {(PTR_W+1){1'b0}};
      valid_r     <= 1'b0;
      addr_r      <= {ADDR_W{1'b0}};
      done_r      <= 1'b0;
      count_r     <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_s;
      rd_ptr_r    <= rd_ptr_s;
      len_r       <= len_s;
      fetch_cnt_r <= fetch_cnt_s;
      valid_r     <= valid_s;
      addr_r      <= addr_s;
      done_r      <= done_s;
      count_r     <= count_s;
    end
  end

  assign miss_valid = valid_r;
  assign miss_addr  = addr_r;
  assign busy       = (state_r == PLAY);
  assign done       = done_r;
  assign miss_count = count_r;

endmodule
